// File: rtl/ex_pkg.sv
// Shared types and defaults for the dv-qualified stream source.
package ex_pkg;

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_EMIT,
        SRC_FINISH
    } src_state_t;

    localparam int DATA_W_DEFAULT = 32;

endpackage

// File: rtl/stream_buf.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous indexed read port.
module stream_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dv_stream_source.sv
// Batch-loaded stream producer: replays buffered words in order, each held HOLD clocks with dv high.
module dv_stream_source
    import ex_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 8,
    parameter int HOLD   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       start,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       dv,
    output logic [DATA_W-1:0]          data_out,
    output logic                       done
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    src_state_t        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              dv_q, dv_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;

    logic              buf_we;
    logic [PW-1:0]     buf_rd_idx;
    logic [DATA_W-1:0] buf_rd_data;

    stream_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PW     (PW)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_idx  (wr_ptr_q),
        .wr_data (wr_data),
        .rd_idx  (buf_rd_idx),
        .rd_data (buf_rd_data)
    );

    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign busy  = (state_q != SRC_IDLE);
    assign dv       = dv_q;
    assign data_out = data_q;
    assign done     = done_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        hold_d     = hold_q;
        dv_d       = dv_q;
        data_d     = data_q;
        done_d     = 1'b0;
        buf_we     = 1'b0;
        buf_rd_idx = rd_ptr_q + PW'(1);

        case (state_q)
            SRC_IDLE: begin
                buf_rd_idx = '0;
                if (start) begin
                    // start takes priority over a same-cycle write, even with an empty buffer
                    if (count_q != '0) begin
                        state_d  = SRC_EMIT;
                        rd_ptr_d = '0;
                        hold_d   = '0;
                        dv_d     = 1'b1;
                        data_d   = buf_rd_data;
                    end
                end else if (wr_en && !full) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = count_q + CW'(1);
                end
            end

            SRC_EMIT: begin
                if (hold_q == HW'(HOLD - 1)) begin
                    hold_d = '0;
                    if ((CW'(rd_ptr_q) + CW'(1)) < count_q) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        data_d   = buf_rd_data;
                    end else begin
                        state_d = SRC_FINISH;
                        dv_d    = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end

            SRC_FINISH: begin
                count_d  = '0;
                wr_ptr_d = '0;
                state_d  = SRC_IDLE;
            end

            default: begin
                state_d = SRC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SRC_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
            dv_q     <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
            dv_q     <= dv_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_dv_stream_source.sv
// Directed bench for dv_stream_source: HOLD=3 and HOLD=1 instances with hand-computed expectations.
module tb_dv_stream_source;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // HOLD=3 instance
    logic        reset3, wr_en3, start3;
    logic [31:0] wr_data3;
    logic        full3, busy3, dv3, done3;
    logic [3:0]  count3;
    logic [31:0] data3;

    // HOLD=1 instance
    logic        reset1, wr_en1, start1;
    logic [31:0] wr_data1;
    logic        full1, busy1, dv1, done1;
    logic [3:0]  count1;
    logic [31:0] data1;

    dv_stream_source #(.DATA_W(32), .DEPTH(8), .HOLD(3)) dut3 (
        .clk(clk), .reset(reset3), .wr_en(wr_en3), .wr_data(wr_data3), .start(start3),
        .full(full3), .count(count3), .busy(busy3), .dv(dv3), .data_out(data3), .done(done3)
    );

    dv_stream_source #(.DATA_W(32), .DEPTH(8), .HOLD(1)) dut1 (
        .clk(clk), .reset(reset1), .wr_en(wr_en1), .wr_data(wr_data1), .start(start1),
        .full(full1), .count(count1), .busy(busy1), .dv(dv1), .data_out(data1), .done(done1)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load3(input logic [31:0] v);
        wr_en3 = 1'b1; wr_data3 = v;
        tick();
        wr_en3 = 1'b0;
    endtask

    // Pulses start and walks the whole replay, checking every cycle against exp_q[0..n-1].
    task automatic replay3(input int n, output logic [31:0] maxv);
        int dvcnt = 0;
        maxv = '0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < n * 3 + 2; k++) begin
            if (k < n * 3) begin
                check("dv_high", dv3, 1);
                check("data", data3, exp_q[k / 3]);
                check("no_done", done3, 0);
                check("busy", busy3, 1);
            end else if (k == n * 3) begin
                check("dv_fall", dv3, 0);
                check("done_pulse", done3, 1);
                check("data_hold", data3, exp_q[n - 1]);
            end else begin
                check("done_clear", done3, 0);
                check("count_clr", count3, 0);
                check("busy_clr", busy3, 0);
            end
            if (dv3) begin
                dvcnt++;
                if (data3 > maxv) maxv = data3;
            end
            tick();
        end
        check("dv_cycles", dvcnt, n * 3);
    endtask

    initial begin
        logic [31:0] mx;
        reset3 = 1'b1; wr_en3 = 1'b0; start3 = 1'b0; wr_data3 = '0;
        reset1 = 1'b1; wr_en1 = 1'b0; start1 = 1'b0; wr_data1 = '0;
        tick();
        tick();
        check("rst_dv", dv3, 0);
        check("rst_data", data3, 0);
        check("rst_done", done3, 0);
        check("rst_busy", busy3, 0);
        check("rst_count", count3, 0);
        check("rst_full", full3, 0);
        reset3 = 1'b0; reset1 = 1'b0;
        tick();

        // Six-value replay; the detector window sees max 11
        exp_q[0] = 3; exp_q[1] = 5; exp_q[2] = 2; exp_q[3] = 7; exp_q[4] = 11; exp_q[5] = 0;
        for (int i = 0; i < 6; i++) load3(exp_q[i]);
        check("count6", count3, 6);
        check("idle_busy", busy3, 0);
        replay3(6, mx);
        check("detector_max", mx, 11);

        // Empty start and start+wr_en collision
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("empty_dv", dv3, 0);
        check("empty_busy", busy3, 0);
        check("empty_done", done3, 0);
        tick();
        check("empty_done2", done3, 0);
        check("empty_busy2", busy3, 0);
        start3 = 1'b1; wr_en3 = 1'b1; wr_data3 = 32'h55;
        tick();
        start3 = 1'b0; wr_en3 = 1'b0;
        check("collide_count", count3, 0);
        check("collide_dv", dv3, 0);

        // Fill past DEPTH
        for (int i = 0; i < 9; i++) begin
            load3(32'd100 + 32'(i));
            if (i == 6) check("not_full7", full3, 0);
            if (i == 7) begin
                check("full8", full3, 1);
                check("count8", count3, 8);
            end
            if (i == 8) check("count_drop9", count3, 8);
        end
        for (int i = 0; i < 8; i++) exp_q[i] = 32'd100 + 32'(i);
        replay3(8, mx);
        check("fill_max", mx, 107);

        // Reset on the second word, then a clean reload
        for (int i = 0; i < 4; i++) load3(32'(i + 1));
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick(); tick(); tick();
        check("mid_word2", data3, 2);
        check("mid_dv", dv3, 1);
        reset3 = 1'b1;
        tick();
        reset3 = 1'b0;
        check("rst_mid_dv", dv3, 0);
        check("rst_mid_count", count3, 0);
        check("rst_mid_done", done3, 0);
        check("rst_mid_busy", busy3, 0);
        tick();
        check("rst_mid_done2", done3, 0);
        exp_q[0] = 32'd10; exp_q[1] = 32'd20;
        load3(exp_q[0]);
        load3(exp_q[1]);
        replay3(2, mx);

        // HOLD=1 back-to-back, with writes attempted during EMIT
        wr_en1 = 1'b1; wr_data1 = 32'hFFFF_FFFF;
        tick();
        wr_data1 = 32'h1;
        tick();
        wr_en1 = 1'b0;
        check("h1_count", count1, 2);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("h1_dv0", dv1, 1);
        check("h1_data0", data1, 32'hFFFF_FFFF);
        wr_en1 = 1'b1; wr_data1 = 32'h5;
        tick();
        wr_en1 = 1'b0;
        check("h1_dv1", dv1, 1);
        check("h1_data1", data1, 32'h1);
        check("h1_count_emit", count1, 2);
        tick();
        check("h1_dv_fall", dv1, 0);
        check("h1_done", done1, 1);
        tick();
        check("h1_done_clr", done1, 0);
        check("h1_count_clr", count1, 0);
        check("h1_busy", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
